// File: rtl/csa_pkg.sv
// -----------------------------------------------------------------------------
// csa_pkg
//   Shared definitions for the carry-save accumulator sequencer:
//   - state_t      : FSM state encoding (IDLE/ACCUM/RESOLVE/DONE)
//   - DEF_*        : default parameter values of the block
//   - NCHUNK_DEF   : resolve chunk count for the default AW/RW
//   - chunk_count(): resolve chunk count for any AW/RW pair
//   - sat_inc()    : increment that saturates at the all-ones value of a
//                    given width
// -----------------------------------------------------------------------------
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned DEF_DW = 32;
  localparam int unsigned DEF_AW = 40;
  localparam int unsigned DEF_RW = 8;
  localparam int unsigned DEF_CW = 16;

  localparam int unsigned NCHUNK_DEF = DEF_AW / DEF_RW;

  // Number of RW-bit chunks the resolve phase walks through.
  function automatic int unsigned chunk_count(input int unsigned aw,
                                              input int unsigned rw);
    return aw / rw;
  endfunction

  // v + 1, clamped at 2^w - 1. Valid for 1 <= w <= 63; callers cast the
  // result back to their own counter width.
  function automatic logic [63:0] sat_inc(input logic [63:0]   v,
                                          input int unsigned   w);
    logic [63:0] max_val;
    max_val = (64'd1 << w) - 64'd1;
    return (v >= max_val) ? max_val : v + 64'd1;
  endfunction

endpackage : csa_pkg

// File: rtl/csa32.sv
// -----------------------------------------------------------------------------
// csa32
//   Bitwise 3:2 carry-save compressor. Reduces three DW-bit addends to a
//   sum vector and a carry vector such that x + y + z == sum + (carry << 1).
//   The shift of the carry vector is left to the caller, which decides what
//   happens to the carry leaving the top bit.
//
// Ports
//   x, y, z  in   DW  addends
//   sum      out  DW  bitwise XOR of the addends
//   carry    out  DW  bitwise majority of the addends (unshifted)
// -----------------------------------------------------------------------------
module csa32 #(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic [DW-1:0] z,
  output logic [DW-1:0] sum,
  output logic [DW-1:0] carry
);

  assign sum   = x ^ y ^ z;
  assign carry = (x & y) | (x & z) | (y & z);

endmodule : csa32

// File: rtl/csa_accum_ctrl.sv
// -----------------------------------------------------------------------------
// csa_accum_ctrl
//   Sums a packet of DW-bit operands modulo 2^AW without carry propagation in
//   the accumulate path. Each accepted beat is folded into a running
//   sum/carry pair through a 3:2 compressor. After the last beat the pair is
//   resolved by a chunked ripple add (RW bits per cycle, LSB chunk first) and
//   the total is presented on a valid/ready output together with the beat
//   count (saturating at 2^CW-1). AW must be a multiple of RW.
//
// Parameters
//   DW  operand width (zero-extended to AW)
//   AW  accumulator / result width
//   RW  resolve chunk width
//   CW  beat counter width
//
// Ports
//   clk        in   1   clock, rising edge
//   nreset     in   1   synchronous active-low reset
//   in_valid   in   1   operand beat valid
//   in_data    in   DW  operand
//   in_last    in   1   last beat of the packet
//   in_ready   out  1   a beat is accepted this cycle when in_valid is high
//   out_valid  out  1   result valid
//   out_data   out  AW  packet sum mod 2^AW
//   out_count  out  CW  packet beat count, saturating
//   out_ready  in   1   consumer takes the result
//
// Timing
//   The edge that accepts the last beat moves the FSM to RESOLVE. Chunks are
//   resolved on the following AW/RW edges, the FSM then enters DONE and the
//   output registers load on the next edge, so out_valid rises AW/RW+1 edges
//   after the last accept.
// -----------------------------------------------------------------------------
module csa_accum_ctrl
  import csa_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned RW = DEF_RW,
  parameter int unsigned CW = DEF_CW
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [AW-1:0] out_data,
  output logic [CW-1:0] out_count,
  input  logic          out_ready
);

  localparam int unsigned NCHUNK = chunk_count(AW, RW);
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned BW     = (AW > 1) ? $clog2(AW) : 1;
  localparam logic [KW-1:0] LAST_CHUNK = KW'(NCHUNK - 1);

  state_t        state;
  logic [AW-1:0] s_q;        // running sum vector
  logic [AW-1:0] c_q;        // running carry vector, already shifted
  logic [CW-1:0] cnt;        // beats accepted in this packet
  logic          cin;        // carry between resolve chunks
  logic [KW-1:0] chunk;      // chunk being resolved

  logic          accept;
  logic [AW-1:0] operand;
  logic [AW-1:0] csa_sum;
  logic [AW-1:0] csa_carry;
  logic [BW-1:0] base;
  logic [RW:0]   chunk_sum;

  // ---------------------------------------------------------------------------
  // Input handshake. in_ready follows nreset directly so that no beat is
  // taken while reset is asserted, whatever state the FSM was left in.
  // ---------------------------------------------------------------------------
  assign in_ready = nreset & ((state == IDLE) | (state == ACCUM));
  assign accept   = in_valid & in_ready;
  assign operand  = AW'(in_data);

  csa32 #(
    .DW (AW)
  ) u_csa (
    .x     (s_q),
    .y     (c_q),
    .z     (operand),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // ---------------------------------------------------------------------------
  // One RW-bit slice of the carry-propagate add.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb receives a value on every path
  // (here unconditionally) so that no latch is inferred.
  always_comb begin
    base      = BW'(chunk) * BW'(RW);
    chunk_sum = {1'b0, s_q[base +: RW]} + {1'b0, c_q[base +: RW]}
              + {{RW{1'b0}}, cin};
  end

  // ---------------------------------------------------------------------------
  // Sequencer, datapath state and registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments only, so every
  // right-hand side below reads the value from before this edge.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= IDLE;
      s_q       <= '0;
      c_q       <= '0;
      cnt       <= '0;
      cin       <= 1'b0;
      chunk     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            s_q <= csa_sum;
            // The carry vector weighs twice the sum vector; the carry out of
            // bit AW-1 falls off, which is exactly the mod 2^AW wrap.
            c_q <= {csa_carry[AW-2:0], 1'b0};
            cnt <= CW'(sat_inc(64'(cnt), CW));
            if (in_last) begin
              state <= RESOLVE;
              cin   <= 1'b0;
              chunk <= '0;
            end else begin
              state <= ACCUM;
            end
          end
        end

        RESOLVE: begin
          // c_q chunks are left as they are; they are cleared on the way
          // back to IDLE.
          s_q[base +: RW] <= chunk_sum[RW-1:0];
          cin             <= chunk_sum[RW];
          if (chunk == LAST_CHUNK) begin
            state <= DONE;
          end else begin
            chunk <= chunk + KW'(1);
          end
        end

        DONE: begin
          if (!out_valid) begin
            // First DONE cycle: capture the resolved sum. The output
            // registers then hold until the consumer takes them.
            out_valid <= 1'b1;
            out_data  <= s_q;
            out_count <= cnt;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            s_q       <= '0;
            c_q       <= '0;
            cnt       <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : csa_accum_ctrl

// File: tb/tb_csa_accum_ctrl.sv
// -----------------------------------------------------------------------------
// tb_csa_accum_ctrl
//   Directed bench for csa_accum_ctrl. Two instances share all inputs: one
//   with default parameters and one with CW=4, whose beat count saturates
//   at 15. Inputs change on the falling edge or 1 time unit after the rising
//   edge; outputs are sampled at those same points.
// -----------------------------------------------------------------------------
module tb_csa_accum_ctrl;

  logic        clk;
  logic        nreset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [39:0] out_data;
  logic [15:0] out_count;

  logic        in_ready4;
  logic        out_valid4;
  logic [39:0] out_data4;
  logic [3:0]  out_count4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;

  csa_accum_ctrl dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ready (out_ready)
  );

  csa_accum_ctrl #(
    .CW (4)
  ) dut4 (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready4),
    .out_valid (out_valid4),
    .out_data  (out_data4),
    .out_count (out_count4),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Presents one beat and holds it until it is accepted. Returns 1 time unit
  // after the accepting edge with accept_cyc recording that edge.
  task automatic send_beat(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL beat_accept_timeout in_ready=%b required=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_valid   = 1'b0;
    in_last    = 1'b0;
  endtask

  // Waits for the result of the packet whose last beat was just accepted,
  // checks latency and contents on both instances, then completes the
  // handshake and checks the return to IDLE.
  task automatic collect(input string       name,
                         input logic [39:0] exp_data,
                         input logic [15:0] exp_count,
                         input logic [3:0]  exp_count4);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid_timeout out_valid=%b required=1", name, out_valid);
      return;
    end
    checks++;
    if ((cyc - accept_cyc) !== 6) begin
      errors++;
      $display("FAIL %s_latency got=%0d required=6", name, cyc - accept_cyc);
    end
    checks++;
    if (out_data !== exp_data) begin
      errors++;
      $display("FAIL %s_data got=%h required=%h", name, out_data, exp_data);
    end
    checks++;
    if (out_count !== exp_count) begin
      errors++;
      $display("FAIL %s_count got=%0d required=%0d", name, out_count, exp_count);
    end
    checks++;
    if (out_valid4 !== 1'b1 || out_data4 !== exp_data) begin
      errors++;
      $display("FAIL %s_cw4_data valid=%b got=%h required=%h", name, out_valid4,
               out_data4, exp_data);
    end
    checks++;
    if (out_count4 !== exp_count4) begin
      errors++;
      $display("FAIL %s_cw4_count got=%0d required=%0d", name, out_count4,
               exp_count4);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release out_valid=%b in_ready=%b required 0,1", name,
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    nreset    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got=%b required=0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 40'd0 || out_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs valid=%b data=%h count=%0d required 0,0,0",
               out_valid, out_data, out_count);
    end
    nreset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready got=%b required=1", in_ready);
    end
  endtask

  task automatic test_basic();
    send_beat(32'd5, 1'b0);
    send_beat(32'd7, 1'b0);
    send_beat(32'd9, 1'b1);
    collect("basic", 40'd21, 16'd3, 4'd3);
  endtask

  task automatic test_single();
    send_beat(32'hFFFF_FFFF, 1'b1);
    collect("single", 40'h00_FFFF_FFFF, 16'd1, 4'd1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 300; i++) begin
      send_beat(32'hFFFF_FFFF, (i == 299));
    end
    collect("wrap", 40'h2B_FFFF_FED4, 16'd300, 4'd15);
  endtask

  task automatic test_backpressure();
    int n;
    n = 0;
    send_beat(32'd100, 1'b0);
    send_beat(32'd200, 1'b1);
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 40'd300 || out_count !== 16'd2
          || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d valid=%b data=%0d count=%0d in_ready=%b required 1,300,2,0",
                 i, out_valid, out_data, out_count, in_ready);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release out_valid=%b in_ready=%b required 0,1",
               out_valid, in_ready);
    end
  endtask

  // The second packet's beat is offered while the first is still resolving;
  // it must wait through RESOLVE/DONE and then be taken.
  task automatic test_back_to_back();
    send_beat(32'd2, 1'b1);
    fork
      send_beat(32'd3, 1'b1);
      collect("b2b_first", 40'd2, 16'd1, 4'd1);
    join
    collect("b2b_second", 40'd3, 16'd1, 4'd1);
  endtask

  task automatic test_reset_mid();
    send_beat(32'd4, 1'b0);
    send_beat(32'd6, 1'b0);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_in_ready got=%b required=0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 40'd0 || out_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_outputs valid=%b data=%h count=%0d required 0,0,0",
               out_valid, out_data, out_count);
    end
    @(negedge clk);
    nreset = 1'b1;
    send_beat(32'd1, 1'b1);
    collect("after_reset", 40'd1, 16'd1, 4'd1);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      send_beat(32'd1, (i == 19));
    end
    collect("saturate", 40'd20, 16'd20, 4'd15);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_csa_accum_ctrl
